// File: rtl/proc_itr_ctrl.sv
// Interrupt controller: rising-edge pending latch, mask, fixed priority, one-cycle itr pulse, ID read ack; ITR_TIMER_EN adds a periodic timer source.
// Latency: source edge to itr pulse 2 cycles; id_data/id_sel are combinational on req_in/addr_in.
// Backpressure: none; after a pulse, further interrupts are held in pending until the core reads the ID.
module proc_itr_ctrl #(
   parameter int NUBITS = 16,
   parameter int NUIOIN = 2,
   parameter int NUIOOU = 2,
   parameter int NSRC   = 4,
   parameter int MSKADD = 0,
   parameter int TMRADD = 1,
   parameter int IDADD  = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NSRC-1:0]           src,
   input  logic                      out_en,
   input  logic [$clog2(NUIOOU)-1:0] addr_out,
   input  logic [NUBITS-1:0]         io_out,
   input  logic                      req_in,
   input  logic [$clog2(NUIOIN)-1:0] addr_in,
   output logic [NUBITS-1:0]         id_data,
   output logic                      id_sel,
   output logic                      itr
);

`ifdef ITR_TIMER_EN
   localparam int NS = NSRC + 1;
`else
   localparam int NS = NSRC;
`endif
   localparam int IW  = (NS > 1) ? $clog2(NS) : 1;
   localparam int AOW = $clog2(NUIOOU);
   localparam int AIW = $clog2(NUIOIN);
   localparam logic [AOW-1:0] MSK_A = MSKADD[AOW-1:0];
   localparam logic [AIW-1:0] ID_A  = IDADD[AIW-1:0];

   typedef enum logic [1:0] {IDLE, FIRE, WAIT} state_t;

   state_t          state;
   logic [NSRC-1:0] src_q;
   logic [NS-1:0]   pending;
   logic [NS-1:0]   mask;
   logic [NS-1:0]   act;
   logic [NS-1:0]   edge_v;
   logic [NS-1:0]   clr;
   logic [IW-1:0]   win;
   logic            any;
   logic            id_rd;
   logic            msk_wr;

   assign act    = pending & mask;
   assign any    = |act;
   assign id_rd  = req_in && (addr_in == ID_A);
   assign msk_wr = out_en && (addr_out == MSK_A);

   // Scan from the top so the lowest active index is the last one written.
   always_comb begin
      win = '0;
      for (int i = NS - 1; i >= 0; i--) begin
         if (act[i]) win = IW'(i);
      end
   end

   always_comb begin
      clr = '0;
      if (id_rd && any) clr = NS'(1) << win;
   end

   assign id_sel  = id_rd;
   assign id_data = (id_rd && any) ? {1'b1, {(NUBITS-1-IW){1'b0}}, win} : '0;

`ifdef ITR_TIMER_EN
   localparam logic [AOW-1:0] TMR_A = TMRADD[AOW-1:0];

   logic [NUBITS-1:0] period;
   logic [NUBITS-1:0] count;
   logic              tick;

   assign tick = (period != '0) && (count == period - 1'b1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period <= '0;
         count  <= '0;
      end else if (out_en && addr_out == TMR_A) begin
         period <= io_out;
         count  <= '0;
      end else if (tick) begin
         count <= '0;
      end else if (period != '0) begin
         count <= count + 1'b1;
      end
   end

   // The timer tick behaves as a rising edge on source index NSRC.
   assign edge_v = {tick, src & ~src_q};
`else
   logic unused_ok;
   assign unused_ok = &{1'b0, io_out[NUBITS-1:NS], TMRADD[0]};
   assign edge_v    = src & ~src_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q   <= '1;
         pending <= '0;
         mask    <= '0;
         state   <= IDLE;
         itr     <= 1'b0;
      end else begin
         src_q   <= src;
         // A fresh edge beats the acknowledge clear on the same bit.
         pending <= (pending & ~clr) | edge_v;
         if (msk_wr) mask <= io_out[NS-1:0];
         itr <= 1'b0;
         case (state)
            IDLE: begin
               if (any) begin
                  state <= FIRE;
                  itr   <= 1'b1;
               end
            end
            FIRE:    state <= WAIT;
            WAIT:    if (id_rd) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_proc_itr_ctrl.sv
// Bench for proc_itr_ctrl: directed cases plus random traffic against a cycle-level reference model.
module tb_proc_itr_ctrl;
`ifdef ITR_TIMER_EN
   localparam int NS = 5;
`else
   localparam int NS = 4;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  src = 4'b0011;
   logic        out_en = 1'b0;
   logic [0:0]  addr_out = 1'b0;
   logic [15:0] io_out = 16'h0;
   logic        req_in = 1'b0;
   logic [0:0]  addr_in = 1'b0;
   logic [15:0] id_data;
   logic        id_sel;
   logic        itr;

   always #5 clk = ~clk;

   proc_itr_ctrl dut (
      .clk(clk), .rst(rst), .src(src), .out_en(out_en), .addr_out(addr_out),
      .io_out(io_out), .req_in(req_in), .addr_in(addr_in),
      .id_data(id_data), .id_sel(id_sel), .itr(itr)
   );

   typedef struct { int cyc; logic [15:0] dat; } id_exp_t;
   int      itr_q[$];
   id_exp_t id_q[$];
   int      cyc = 0;
   int      n_tests = 0;
   int      n_fail = 0;
   logic [3:0] cur_src = 4'b0011;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference model: pending set per source, mask, and "pulse due"/"awaiting ack" flags.
   bit [4:0] m_pend, m_mask;
   bit [3:0] m_prev;
   bit       m_itr, m_wait;
   int       m_period, m_count;

   task automatic model_reset();
      m_pend = 0; m_mask = 0; m_prev = 4'hF; m_itr = 0; m_wait = 0;
      m_period = 0; m_count = 0;
   endtask

   task automatic model_eval();
      bit [4:0] act, ev;
      int win;
      bit rdv;
      logic [15:0] e;
      act = m_pend & m_mask;
      win = -1;
      for (int i = 0; i < NS; i++) if (act[i] && win < 0) win = i;
      rdv = req_in && addr_in == 1'b0;
      e = 16'h0;
      if (rdv && win >= 0) e = 16'h8000 | 16'(win);
      if (rdv) id_q.push_back('{cyc, e});
      if (m_itr) itr_q.push_back(cyc);
      ev = {1'b0, src & ~m_prev};
`ifdef ITR_TIMER_EN
      if (m_period != 0 && m_count == m_period - 1) begin
         ev[4] = 1'b1;
         m_count = 0;
      end else if (m_period != 0) begin
         m_count++;
      end
      if (out_en && addr_out == 1'b1) begin
         m_period = int'(io_out);
         m_count = 0;
      end
`endif
      if (rdv && win >= 0) m_pend = m_pend & ~(5'd1 << win);
      m_pend = m_pend | ev;
      if (m_itr) begin
         m_itr = 0;
         m_wait = 1;
      end else if (m_wait) begin
         if (rdv) m_wait = 0;
      end else if (act != 0) begin
         m_itr = 1;
      end
      if (out_en && addr_out == 1'b0) m_mask = 5'(io_out) & 5'((1 << NS) - 1);
      m_prev = src;
   endtask

   task automatic step(input logic [3:0] s, input logic oe, input logic ao,
                       input logic [15:0] io, input logic rq, input logic ai);
      @(posedge clk);
      #1;
      src = s; out_en = oe; addr_out = ao; io_out = io; req_in = rq; addr_in = ai;
      cur_src = s;
      model_eval();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(cur_src, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic idle_itr(input logic exp);
      idle(1);
      chk("itr_timing", {31'b0, itr}, {31'b0, exp});
   endtask

   task automatic wr_mask(input logic [15:0] m);
      step(cur_src, 1'b1, 1'b0, m, 1'b0, 1'b0);
   endtask

   task automatic rd_chk(input logic [15:0] exp);
      step(cur_src, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      chk("id_sel_on_read", {31'b0, id_sel}, 32'd1);
      chk("id_data_read", {16'b0, id_data}, {16'b0, exp});
   endtask

   task automatic reset_release();
      out_en = 1'b0; req_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      model_eval();
      #1;
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an interrupt or an ID word.
   always @(negedge clk) begin
      if (!rst) begin
         if (itr) begin
            if (itr_q.size() == 0) begin
               chk("itr_unexpected", 32'd1, 32'd0);
            end else begin
               chk("itr_cycle", cyc, itr_q.pop_front());
            end
         end
         if (id_sel) begin
            if (id_q.size() == 0) begin
               chk("id_unexpected", 32'd1, 32'd0);
            end else begin
               id_exp_t e;
               e = id_q.pop_front();
               chk("id_cycle", cyc, e.cyc);
               chk("id_data", {16'b0, id_data}, {16'b0, e.dat});
            end
         end else begin
            chk("id_data_idle", {16'b0, id_data}, 32'd0);
         end
      end
   end

   initial begin
      logic [3:0]  s;
      logic        oe, ao, rq, ai;
      logic [15:0] io;

      model_reset();
      #3;
      chk("rst_itr", {31'b0, itr}, 32'd0);
      chk("rst_id_sel", {31'b0, id_sel}, 32'd0);
      chk("rst_id_data", {16'b0, id_data}, 32'd0);

      // Lines already high at reset release must not register as edges.
      reset_release();
      for (int i = 0; i < 20; i++) idle_itr(1'b0);
      wr_mask(16'h000F);
      rd_chk(16'h0000);
      step(4'b0000, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(2);

      // Single source
      wr_mask(16'h0004);
      step(4'b0100, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk("single_t", {31'b0, itr}, 32'd0);
      step(4'b0000, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk("single_t1", {31'b0, itr}, 32'd0);
      idle_itr(1'b1);
      idle_itr(1'b0);
      rd_chk(16'h8002);
      idle(2);

      // Priority
      wr_mask(16'h000F);
      step(4'b1010, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(3);
      rd_chk(16'h8001);
      idle_itr(1'b0);
      idle_itr(1'b1);
      idle(1);
      rd_chk(16'h8003);
      idle(2);
      rd_chk(16'h0000);
      step(4'b0000, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(2);

      // Masked sources latch but stay quiet until unmasked
      wr_mask(16'h0000);
      step(4'b0001, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) idle_itr(1'b0);
      wr_mask(16'h0001);
      chk("mask_m", {31'b0, itr}, 32'd0);
      idle_itr(1'b0);
      idle_itr(1'b1);
      idle(2);
      rd_chk(16'h8000);
      idle(2);

      // Clear/set race on the acknowledged bit
      wr_mask(16'h000F);
      step(4'b0000, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(3);
      step(4'b0000, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      chk("race_id", {16'b0, id_data}, 32'h8001);
      idle_itr(1'b0);
      idle_itr(1'b1);
      idle(1);
      rd_chk(16'h8001);
      idle(2);

      // Reset while itr is high
      step(4'b0000, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      step(4'b0100, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      step(4'b0100, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      chk("itr_before_rst", {31'b0, itr}, 32'd1);
      rst = 1'b1;
      #1;
      chk("itr_async_rst", {31'b0, itr}, 32'd0);
      itr_q.delete();
      id_q.delete();
      reset_release();
      idle_itr(1'b0);
      wr_mask(16'h000F);
      idle(3);
      rd_chk(16'h0000);

`ifdef ITR_TIMER_EN
      wr_mask(16'h0010);
      step(cur_src, 1'b1, 1'b1, 16'd5, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         if (m_wait) rd_chk(16'h8004);
         else idle(1);
      end
      step(cur_src, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0);
      repeat (3) begin
         idle(4);
         if (m_wait) rd_chk(16'h8004);
      end
      for (int i = 0; i < 20; i++) idle_itr(1'b0);
`endif

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         s  = cur_src ^ (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
         oe = ($urandom_range(0, 19) == 0);
         ao = 1'($urandom_range(0, 1));
         io = 16'($urandom_range(0, 31));
         rq = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         ai = ($urandom_range(0, 3) == 0);
         step(s, oe, ao, io, rq, ai);
      end

      idle(3);
      @(negedge clk);
      #1;
      chk("itr_q_drained", itr_q.size(), 32'd0);
      chk("id_q_drained", id_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
